// File: rtl/text_pkg.sv
// Shared widths, control codes and FSM encoding for the text RAM writer.
package text_pkg;

    localparam int ROW_W  = 5;
    localparam int COL_W  = 5;
    localparam int DATA_W = 8;

    localparam logic [7:0] CMD_NEWLINE = 8'h80;
    localparam logic [7:0] CMD_HOME    = 8'h81;
    localparam logic [7:0] CMD_CLEAR   = 8'h82;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_WR = 2'd1,
        ST_CLEAR   = 2'd2
    } state_t;

endpackage

// File: rtl/text_cursor.sv
// Row/column cursor for the text RAM writer.
// TEXT_RAM_WRITER_WRAP_FLAG_EN enables the registered wrap pulse; otherwise wrapped is tied low.
module text_cursor #(
    parameter int ROW_W = 5,
    parameter int COL_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    input  logic             newline,
    input  logic             home,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             wrapped
);

    logic col_last;
    logic row_last;

    assign col_last = (col == {COL_W{1'b1}});
    assign row_last = (row == {ROW_W{1'b1}});

    // Row and column roll over naturally at their full width, giving the 31 -> 0 wrap.
    always_ff @(posedge clk) begin
        if (!reset) begin
            row <= '0;
            col <= '0;
        end else if (home) begin
            row <= '0;
            col <= '0;
        end else if (newline) begin
            row <= row + 1'b1;
            col <= '0;
        end else if (advance) begin
            col <= col + 1'b1;
            if (col_last)
                row <= row + 1'b1;
        end
    end

`ifdef TEXT_RAM_WRITER_WRAP_FLAG_EN
    logic wrap_evt;

    assign wrap_evt = !home && row_last && (newline || (advance && col_last));

    always_ff @(posedge clk) begin
        if (!reset)
            wrapped <= 1'b0;
        else
            wrapped <= wrap_evt;
    end
`else
    assign wrapped = 1'b0;
`endif

endmodule

// File: rtl/text_ram_writer.sv
// Byte-stream writer for the 32x32 text RAM; only drives the RAM port while display_on is low.
// Optional wrap pulse controlled by TEXT_RAM_WRITER_WRAP_FLAG_EN (see text_cursor).
module text_ram_writer #(
    parameter int                ROW_W     = 5,
    parameter int                COL_W     = 5,
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] FILL_CHAR = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   display_on,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [ROW_W+COL_W-1:0] ram_addr,
    output logic [DATA_W-1:0]      ram_din,
    output logic                   ram_we,
    output logic                   ram_own,
    output logic [ROW_W-1:0]       cur_row,
    output logic [COL_W-1:0]       cur_col,
    output logic                   wrapped
);
    import text_pkg::*;

    localparam int ADDR_W = ROW_W + COL_W;

    state_t             state, next_state;
    logic [DATA_W-1:0]  wr_data;
    logic [ADDR_W-1:0]  clr_addr;
    logic               in_ready_c, we_c;
    logic               adv, nl, home;
    logic               latch_ld, clr_start, clr_step;

    text_cursor #(
        .ROW_W (ROW_W),
        .COL_W (COL_W)
    ) u_cursor (
        .clk     (clk),
        .reset   (reset),
        .advance (adv),
        .newline (nl),
        .home    (home),
        .row     (cur_row),
        .col     (cur_col),
        .wrapped (wrapped)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            wr_data  <= '0;
            clr_addr <= '0;
        end else begin
            state <= next_state;
            if (latch_ld)
                wr_data <= DATA_W'(in_data);
            if (clr_start)
                clr_addr <= '0;
            else if (clr_step)
                clr_addr <= clr_addr + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        in_ready_c = 1'b0;
        we_c       = 1'b0;
        ram_addr   = {cur_row, cur_col};
        ram_din    = wr_data;
        adv        = 1'b0;
        nl         = 1'b0;
        home       = 1'b0;
        latch_ld   = 1'b0;
        clr_start  = 1'b0;
        clr_step   = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready_c = 1'b1;
                if (in_valid) begin
                    if (!in_data[7]) begin
                        latch_ld   = 1'b1;
                        next_state = ST_WAIT_WR;
                    end else begin
                        case (in_data)
                            CMD_NEWLINE: nl = 1'b1;
                            CMD_HOME:    home = 1'b1;
                            CMD_CLEAR: begin
                                clr_start  = 1'b1;
                                next_state = ST_CLEAR;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            // Writes only happen in blanking; display_on stalls them in the same cycle.
            ST_WAIT_WR: begin
                if (!display_on) begin
                    we_c       = 1'b1;
                    adv        = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                ram_addr = clr_addr;
                ram_din  = FILL_CHAR;
                if (!display_on) begin
                    we_c     = 1'b1;
                    clr_step = 1'b1;
                    if (clr_addr == {ADDR_W{1'b1}}) begin
                        home       = 1'b1;
                        next_state = ST_IDLE;
                    end
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Handshake and RAM ownership are held off while reset is asserted.
    assign in_ready = in_ready_c & reset;
    assign ram_we   = we_c & reset;
    assign ram_own  = ram_we;

endmodule

// File: doc/text_ram_writer.md
Name: text_ram_writer

Overview:
- Host-side writer for the 32x32 character/tile RAM that the text display scans out.
- Accepts a byte stream over a valid/ready handshake and keeps a cursor. Data bytes go into the RAM at address {row, col}; control bytes move the cursor or clear the screen.
- Owns the RAM address/data/write-enable only while display_on is low (blanking), so it never disturbs the display read path.

Parameters:
- ROW_W, 5, row cursor width (32 rows).
- COL_W, 5, column cursor width (32 columns).
- DATA_W, 8, RAM word width.
- FILL_CHAR, 8'h00, value written to every cell by the clear command.

Ports:
- clk  input  1  system clock; one clock domain.
- reset  input  1  synchronous, active-low reset.
- display_on  input  1  from the video sync generator; 1 = active video, display owns the RAM.
- in_data  input  8  command/data byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  writer can accept a byte this cycle.
- ram_addr  output  ROW_W+COL_W  RAM address {row, col}, meaningful when ram_own=1.
- ram_din  output  DATA_W  RAM write data.
- ram_we  output  1  RAM write enable.
- ram_own  output  1  writer drives the RAM port this cycle; top-level muxes ram_addr on it.
- cur_row  output  ROW_W  current cursor row.
- cur_col  output  COL_W  current cursor column.
- wrapped  output  1  one-cycle pulse on screen wrap; optional, see Optional Feature.

Behaviour:
- Reset: sampled on posedge clk when reset==0. Sets state=IDLE, cursor=(0,0), data latch=0. ram_we=0, ram_own=0, in_ready=0 during reset, wrapped=0.
- States: IDLE, WAIT_WR, CLEAR.
- IDLE:
  - in_ready=1.
  - A transfer happens on a cycle with in_valid && in_ready.
  - in_data[7]==0: latch the byte and go to WAIT_WR.
  - 8'h80 (newline): col=0, row=row+1; stay in IDLE.
  - 8'h81 (home): row=col=0; stay in IDLE.
  - 8'h82 (clear): clear address=0; go to CLEAR.
  - Any other 8'h83..8'hFF: consumed, no effect.
- WAIT_WR:
  - in_ready=0.
  - While display_on==1: hold; ram_we=0, ram_own=0.
  - First cycle with display_on==0:
    - ram_own=1, ram_we=1, ram_addr={row, col}, ram_din=latched byte (combinational from state and display_on).
    - On that clock edge, advance the cursor and return to IDLE.
  - Minimum accept-to-write latency is 1 cycle; the next accept is possible 2 cycles after the previous one.
- Cursor advance: col+1. At col==31: col=0, row+1. At row==31 with col==31: cursor goes to (0,0) and wrapped pulses. Newline on row 31 also wraps to row 0 and pulses wrapped.
- CLEAR:
  - in_ready=0.
  - Each cycle with display_on==0: ram_we=1, ram_addr=clear address, ram_din=FILL_CHAR, then clear address+1.
  - Cycles with display_on==1 pause with no write.
  - After writing address 1023: cursor=(0,0), return to IDLE.
  - A clear takes exactly 1024 blanking cycles.
- display_on rising mid-operation: the write/clear stalls immediately in the same cycle (ram_own drops combinationally). No partial or duplicate write.
- Reset mid-WAIT_WR or mid-CLEAR: the operation is abandoned; cells already written stay written.
- ram_own==ram_we at all times.

Optional Feature:
- Macro: TEXT_RAM_WRITER_WRAP_FLAG_EN.
- Defined: wrapped is a registered one-cycle pulse on the edge where the cursor wraps from row 31 to row 0 (advance or newline). A clear does not pulse it.
- Undefined: the wrapped port still exists, tied to 0; no wrap logic is generated.

Decomposition:
- Shared package (text_pkg): ROW_W, COL_W, DATA_W; control codes CMD_NEWLINE=8'h80, CMD_HOME=8'h81, CMD_CLEAR=8'h82; state encoding.
- One natural sub-module: text_cursor. It holds row/col registers with advance, newline and home inputs and produces the wrap output.
- The FSM and RAM port muxing stay in the top module.

Test Plan:
- Reset with display_on=0, then send 8'h05 -> ram_we for exactly 1 cycle the cycle after accept, ram_addr=0, ram_din=8'h05; cursor=(0,1); in_ready back high the next cycle.
- Hold display_on=1 for 20 cycles after accepting 8'h07 -> ram_we stays 0 throughout; write occurs on the first display_on=0 cycle at addr 0.
- Send 8'h80, then 8'h03 -> write at addr 10'h020 (row 1, col 0); 8'h81 then 8'h04 -> write at addr 0.
- Send 1024 data bytes with display_on=0 -> final write at addr 10'h3FF; cursor=(0,0); wrapped pulses once (macro defined) or stays 0 (undefined).
- Send 8'h82 with display_on toggling 1/0 every 8 cycles -> 1024 writes of FILL_CHAR, none while display_on=1, addresses 0..1023 each exactly once; in_ready=0 until done.
- Assert reset in the middle of CLEAR at address 300 -> next cycle state=IDLE, ram_we=0, cursor=(0,0); cells 0..299 hold FILL_CHAR.
